// File: rtl/led_pkg.sv
// Shared types and default timing for the LED frame sequencer.
// Timing defaults assume a 100 MHz clock driving WS2812-style LEDs.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_LATCH
  } state_e;

  localparam int BITS_PER_LED = 24;

  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_TBIT     = 125;
  localparam int DEF_T0H      = 35;
  localparam int DEF_T1H      = 70;
  localparam int DEF_TRESET   = 5000;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// One-wire bit-slot encoder: slot counter, high-time compare, registered dout.
// Ports: load_i (first slot next cycle), send_i, more_i, bit_i -> dout_o, rotate_o, slot_done_o.
module led_bit_encoder
  import led_pkg::*;
#(
  parameter int TBIT = DEF_TBIT,
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic send_i,
  input  logic more_i,
  input  logic bit_i,
  output logic dout_o,
  output logic rotate_o,
  output logic slot_done_o
);

  localparam int CW = cw(TBIT);
  localparam logic [CW-1:0] LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] HI0  = CW'(T0H);
  localparam logic [CW-1:0] HI1  = CW'(T1H);

  logic [CW-1:0] cnt_q, cnt_d, nxt;
  logic          bit_q, bit_d;
  logic          dout_q, dout_d;
  logic          cur;

  // dout is registered, so each cycle computes the level of the next one.
  // Slot cycle 0 is always high; the sampled bit only sets the falling edge.
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    dout_d = 1'b0;
    nxt    = cnt_q + CW'(1);
    cur    = (cnt_q == '0) ? bit_i : bit_q;
    if (load_i) begin
      cnt_d  = '0;
      dout_d = 1'b1;
    end else if (send_i) begin
      if (cnt_q == '0) bit_d = bit_i;
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        dout_d = more_i;
      end else begin
        cnt_d  = nxt;
        dout_d = nxt < (cur ? HI1 : HI0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o      = dout_q;
  assign rotate_o    = send_i & (cnt_q == LAST);
  assign slot_done_o = send_i & (cnt_q == LAST);

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame FSM: colour command per frame, NUM_LEDS x 24 bit slots, latch gap.
// Ports: clk, reset(n), start, clr/en/nextReq, CurrentBit -> strobes, dout, busy, frameDone.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int TBIT     = DEF_TBIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clrReq,
  input  logic enReq,
  input  logic nextReq,
  input  logic CurrentBit,
  output logic RotateRegisterLeft,
  output logic loadClr,
  output logic loadColor,
  output logic changeColor,
  output logic dout,
  output logic busy,
  output logic frameDone
);

  localparam int BW = cw(BITS_PER_LED);
  localparam int LW = cw(NUM_LEDS);
  localparam int RW = cw(TRESET);
  localparam logic [BW-1:0] BLAST = BW'(BITS_PER_LED - 1);
  localparam logic [LW-1:0] LLAST = LW'(NUM_LEDS - 1);
  localparam logic [RW-1:0] RLAST = RW'(TRESET - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [LW-1:0] led_q, led_d;
  logic [RW-1:0] lat_q, lat_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    req;
  logic          last_bit;
  logic          slot_done;

  assign req      = {clrReq, enReq, nextReq};
  assign last_bit = (bit_q == BLAST) && (led_q == LLAST);

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    led_d       = led_q;
    lat_d       = lat_q;
    pend_d      = pend_q | req;
    loadClr     = 1'b0;
    loadColor   = 1'b0;
    changeColor = 1'b0;
    frameDone   = 1'b0;
    busy        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // A request in this very cycle survives into the next frame.
        pend_d = req;
        if (pend_q[2])      loadClr     = 1'b1;
        else if (pend_q[1]) loadColor   = 1'b1;
        else if (pend_q[0]) changeColor = 1'b1;
        else                loadColor   = 1'b1;
        bit_d   = '0;
        led_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (slot_done) begin
          if (last_bit) begin
            lat_d   = '0;
            state_d = ST_LATCH;
          end else if (bit_q == BLAST) begin
            bit_d = '0;
            led_d = led_q + LW'(1);
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_LATCH: begin
        if (lat_q == RLAST) begin
          frameDone = 1'b1;
          state_d   = start ? ST_LOAD : ST_IDLE;
        end else begin
          lat_d = lat_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      led_q   <= '0;
      lat_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
    end
  end

  led_bit_encoder #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_enc (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (state_q == ST_LOAD),
    .send_i      (state_q == ST_SEND),
    .more_i      (!last_bit),
    .bit_i       (CurrentBit),
    .dout_o      (dout),
    .rotate_o    (RotateRegisterLeft),
    .slot_done_o (slot_done)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: frame-level reference model plus directed
// and randomized request/start traffic against an emulated shift register.
module tb_led_frame_sequencer;

  localparam int NL   = 2;
  localparam int TB   = 10;
  localparam int T0   = 3;
  localparam int T1   = 7;
  localparam int TR   = 20;
  localparam int SLEN = 24 * NL * TB;
  localparam int FLEN = 1 + SLEN + TR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic clrReq = 1'b0;
  logic enReq = 1'b0;
  logic nextReq = 1'b0;
  logic rot, lclr, lcol, lchg, dout, busy, fd;
  logic [23:0] sr = 24'h0;
  int ecidx = 0;

  int checks = 0;
  int passes = 0;

  led_frame_sequencer #(
    .NUM_LEDS (NL),
    .TBIT     (TB),
    .T0H      (T0),
    .T1H      (T1),
    .TRESET   (TR)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .clrReq             (clrReq),
    .enReq              (enReq),
    .nextReq            (nextReq),
    .CurrentBit         (sr[23]),
    .RotateRegisterLeft (rot),
    .loadClr            (lclr),
    .loadColor          (lcol),
    .changeColor        (lchg),
    .dout               (dout),
    .busy               (busy),
    .frameDone          (fd)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pal(input int i);
    case (i)
      0:       return 24'hF00000;
      1:       return 24'h00F000;
      default: return 24'h0000F0;
    endcase
  endfunction

  // Colour source and GRB shift register outside the sequencer.
  always @(posedge clk) begin
    if (!reset) sr <= 24'h0;
    else if (lclr) sr <= 24'h0;
    else if (lcol) sr <= pal(ecidx);
    else if (lchg) begin
      ecidx <= (ecidx + 1) % 3;
      sr    <= pal((ecidx + 1) % 3);
    end else if (rot) sr <= {sr[22:0], sr[23]};
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: phase within a frame (-1 idle), chosen command, word.
  int ph = -1;
  int mch = 0;
  int cidx = 0;
  logic [23:0] mword = 24'h0;
  bit mpc = 0, mpe = 0, mpn = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      ph = -1;
      mpc = 0; mpe = 0; mpn = 0;
    end else begin
      if (ph == 0) begin
        mpc = clrReq; mpe = enReq; mpn = nextReq;
      end else begin
        mpc = mpc | clrReq; mpe = mpe | enReq; mpn = mpn | nextReq;
      end
      if (ph < 0 || ph == FLEN - 1) ph = start ? 0 : -1;
      else ph++;
      if (ph == 0) begin
        if (mpc) begin
          mch = 1; mword = 24'h0;
        end else if (mpe) begin
          mch = 2; mword = pal(cidx);
        end else if (mpn) begin
          mch = 3; cidx = (cidx + 1) % 3; mword = pal(cidx);
        end else begin
          mch = 2; mword = pal(cidx);
        end
      end
    end
  end

  // {dout, busy, frameDone, rotate, loadClr, loadColor, changeColor}
  function automatic logic [6:0] mexp();
    logic [6:0] e;
    int s, k, b;
    logic bv;
    e = '0;
    if (ph == 0) begin
      e[5] = 1'b1;
      e[2] = (mch == 1);
      e[1] = (mch == 2);
      e[0] = (mch == 3);
    end else if (ph > 0 && ph <= SLEN) begin
      s = ph - 1;
      k = s % TB;
      b = (s / TB) % 24;
      bv = mword[23 - b];
      e[5] = 1'b1;
      e[6] = (k < (bv ? T1 : T0));
      e[3] = (k == TB - 1);
    end else if (ph > SLEN) begin
      e[5] = 1'b1;
      e[4] = (ph == FLEN - 1);
    end
    return e;
  endfunction

  // Per-cycle compare plus frame statistics taken from the DUT outputs.
  int cyc = 0, load_cyc = 0, first_hi = -1, hi = 0, rc = 0, sc = 0, code = 0;
  int fdn = 0, fd_cyc = 0, prev_fd = 0, idle_cnt = 0, nstb_all = 0;
  int f_hi = 0, f_rot = 0, f_sc = 0, f_code = 0, f_len = 0, f_first = 0;

  initial forever begin
    logic [6:0] act;
    int nstb;
    @(negedge clk);
    cyc++;
    act = {dout, busy, fd, rot, lclr, lcol, lchg};
    chk("cycle", int'(act), int'(mexp()));
    nstb = int'(lclr) + int'(lcol) + int'(lchg);
    nstb_all += nstb;
    if (nstb != 0) begin
      load_cyc = cyc; hi = 0; rc = 0; sc = 0; first_hi = -1;
      code = lclr ? 1 : (lcol ? 2 : 3);
    end
    sc += nstb;
    if (dout) begin
      hi++;
      if (first_hi < 0) first_hi = cyc - load_cyc;
    end
    if (rot) rc++;
    if (!busy && reset) idle_cnt++;
    if (fd) begin
      prev_fd = fd_cyc; fd_cyc = cyc; fdn++;
      f_hi = hi; f_rot = rc; f_sc = sc; f_code = code;
      f_len = cyc - load_cyc + 1; f_first = first_hi;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int n0, k;
    n0 = fdn;
    k = 0;
    while (fdn == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (fdn == n0) chk("fd_timeout", 0, 1);
  endtask

  task automatic chk_frame(input string nm, input int strobe, input int hcnt);
    chk({nm, "_strobe"}, f_code, strobe);
    chk({nm, "_nstrobe"}, f_sc, 1);
    chk({nm, "_high"}, f_hi, hcnt);
    chk({nm, "_rotates"}, f_rot, 48);
    chk({nm, "_len"}, f_len, FLEN);
    chk({nm, "_first_dout"}, f_first, 1);
  endtask

  initial begin
    int i0, s0, k;
    bit hold;
    #2 reset = 1'b0;
    #1 chk("reset_state", int'({dout, busy, fd, rot, lclr, lcol, lchg}), 0);
    tick(3);
    reset = 1'b1;
    tick(2);

    // 0xF00000: 4 ones and 20 zeros per LED
    pulse_start();
    wait_fd(700);
    chk_frame("t1", 2, 2 * (4 * T1 + 20 * T0));
    tick(3);

    clrReq = 1'b1; tick(1); clrReq = 1'b0;
    tick(2);
    pulse_start();
    wait_fd(700);
    chk_frame("t2", 1, 48 * T0);
    tick(3);

    pulse_start();
    tick(1 + 10 * TB + 2);
    nextReq = 1'b1; tick(1); nextReq = 1'b0;
    wait_fd(700);
    chk_frame("t3a", 2, 176);
    pulse_start();
    wait_fd(700);
    chk_frame("t3b", 3, 176);
    tick(3);

    clrReq = 1'b1; nextReq = 1'b1; tick(1);
    clrReq = 1'b0; nextReq = 1'b0;
    pulse_start();
    wait_fd(700);
    chk_frame("t4a", 1, 144);
    pulse_start();
    wait_fd(700);
    chk_frame("t4b", 2, 176);
    tick(3);

    // Slot 8 of word 0x00F000 is a 1 bit; cycle 4 sits in its high phase.
    pulse_start();
    tick(1 + 8 * TB + 4);
    chk("t5_pre_dout", int'(dout), 1);
    #2 reset = 1'b0;
    #1 chk("t5_async", int'({dout, busy}), 0);
    tick(3);
    reset = 1'b1;
    s0 = nstb_all;
    tick(20);
    chk("t5_no_strobe", nstb_all - s0, 0);
    pulse_start();
    wait_fd(700);
    chk_frame("t5", 2, 176);
    tick(3);

    start = 1'b1;
    wait_fd(700);
    i0 = idle_cnt;
    wait_fd(700);
    chk("t6_period1", fd_cyc - prev_fd, FLEN);
    wait_fd(700);
    chk("t6_period2", fd_cyc - prev_fd, FLEN);
    chk("t6_no_idle", idle_cnt - i0, 0);
    start = 1'b0;
    wait_fd(700);
    tick(3);
    chk("t6_idle_after", int'(busy), 0);

    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 499) == 0) hold = !hold;
      start   = hold | ($urandom_range(0, 30) == 0);
      clrReq  = ($urandom_range(0, 60) == 0);
      enReq   = ($urandom_range(0, 60) == 0);
      nextReq = ($urandom_range(0, 60) == 0);
      tick(1);
    end
    start = 1'b0; clrReq = 1'b0; enReq = 1'b0; nextReq = 1'b0;
    k = 0;
    while (busy && k < 1000) begin
      tick(1);
      k++;
    end
    chk("rand_idle_end", int'(busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
